// File: rtl/aes_job_arbiter.sv
// aes_job_arbiter: round-robin arbiter sharing one multicycle-settled AES datapath between two requesters
// Ports: req0_*/req1_* job handshakes (mode/text/key in, ready out); resp0_*/resp1_* result
// handshakes (data/err out, ready in); core_* operands to the shared datapath, core_result back.
// Optional: define AES_ARB_KAT_EN for a post-reset known-answer self-test (adds kat_done, kat_pass).
module aes_job_arbiter #(
  parameter int MC_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [2:0]   req0_mode,
  input  logic [127:0] req0_text,
  input  logic [255:0] req0_key,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [2:0]   req1_mode,
  input  logic [127:0] req1_text,
  input  logic [255:0] req1_key,
  output logic         resp0_valid,
  input  logic         resp0_ready,
  output logic [127:0] resp0_data,
  output logic         resp0_err,
  output logic         resp1_valid,
  input  logic         resp1_ready,
  output logic [127:0] resp1_data,
  output logic         resp1_err,
  output logic [2:0]   core_mode,
  output logic [127:0] core_text,
  output logic [255:0] core_key,
  input  logic [127:0] core_result
`ifdef AES_ARB_KAT_EN
  ,
  output logic         kat_done,
  output logic         kat_pass
`endif
);
`ifdef AES_ARB_KAT_EN
  typedef enum logic [1:0] {IDLE, WAIT, RESP, KAT} state_t;
  localparam state_t ST_RST = KAT;
`else
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam state_t ST_RST = IDLE;
`endif
  localparam logic [3:0] MC_LOAD = 4'(MC_CYCLES - 1);
  state_t st, st_nx;
  logic ptr, id, err, acc, bad, done, resp_hs;
  logic [127:0] res;
  logic [3:0] cnt;
  logic [2:0] sel_mode;
  assign acc = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign sel_mode = req1_ready ? req1_mode : req0_mode;
  assign bad = sel_mode[1:0] == 2'b11;
  assign done = st == WAIT && cnt == '0;
  assign resp_hs = st == RESP && (id ? resp1_ready : resp0_ready);
  assign resp0_data = resp0_valid ? res : '0;
  assign resp1_data = resp1_valid ? res : '0;
  assign resp0_err = resp0_valid && err;
  assign resp1_err = resp1_valid && err;
`ifdef AES_ARB_KAT_EN
  localparam logic [127:0] KPT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KC128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KC192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] KC256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KK256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KK192 = 256'h000102030405060708090a0b0c0d0e0f10111213141516170000000000000000;
  localparam logic [255:0] KK128 = 256'h000102030405060708090a0b0c0d0e0f00000000000000000000000000000000;
  logic [2:0] kidx;
  logic [1:0] ksz;
  logic kdec, kat_bad;
  logic [127:0] kct, kexp;
  assign kdec = kidx >= 3'd3;
  assign ksz = kdec ? 2'(kidx - 3'd3) : kidx[1:0];
  assign kct = ksz == 2'd0 ? KC128 : ksz == 2'd1 ? KC192 : KC256;
  // decrypt jobs feed the known ciphertext back in and expect the plaintext
  assign kexp = kdec ? KPT : kct;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      kidx <= '0;
      kat_bad <= 1'b0;
      kat_done <= 1'b0;
      kat_pass <= 1'b0;
    end else if (done && !kat_done) begin
      kidx <= kidx + 3'd1;
      kat_bad <= kat_bad || core_result != kexp;
      if (kidx == 3'd5) begin
        kat_done <= 1'b1;
        kat_pass <= !kat_bad && core_result == kexp;
      end
    end
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= ST_RST;
    else st <= st_nx;
  always_comb begin
    st_nx = st;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    case (st)
      IDLE: begin
        req0_ready = req0_valid && (!req1_valid || !ptr);
        req1_ready = req1_valid && (!req0_valid || ptr);
        st_nx = (req0_ready || req1_ready) ? (bad ? RESP : WAIT) : IDLE;
      end
      WAIT: if (cnt == '0) begin
`ifdef AES_ARB_KAT_EN
        st_nx = kat_done ? RESP : kidx == 3'd5 ? IDLE : KAT;
`else
        st_nx = RESP;
`endif
      end
      RESP: begin
        resp0_valid = !id;
        resp1_valid = id;
        st_nx = resp_hs ? IDLE : RESP;
      end
`ifdef AES_ARB_KAT_EN
      KAT: st_nx = WAIT;
`endif
      default: st_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr <= 1'b0;
      id <= 1'b0;
      err <= 1'b0;
      res <= '0;
      cnt <= '0;
      core_mode <= '0;
      core_text <= '0;
      core_key <= '0;
    end else begin
      if (acc) begin
        id <= req1_ready;
        err <= bad;
        res <= '0;
        // illegal jobs never reach the datapath, so the operands keep the last legal job
        if (!bad) begin
          core_mode <= sel_mode;
          core_text <= req1_ready ? req1_text : req0_text;
          core_key <= req1_ready ? req1_key : req0_key;
          cnt <= MC_LOAD;
        end
      end
      if (st == WAIT && cnt != '0) cnt <= cnt - 4'd1;
      if (done) res <= core_result;
      if (resp_hs) ptr <= ~id;
`ifdef AES_ARB_KAT_EN
      if (st == KAT) begin
        core_mode <= {kdec, ksz};
        core_text <= kdec ? kct : KPT;
        core_key <= ksz == 2'd0 ? KK128 : ksz == 2'd1 ? KK192 : KK256;
        cnt <= MC_LOAD;
      end
`endif
    end
endmodule

// File: tb/tb_aes_job_arbiter.sv
// tb_aes_job_arbiter: scoreboard bench for aes_job_arbiter with a stand-in datapath model
module tb_aes_job_arbiter;
  localparam int MC = 2;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [255:0] KF = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] K192 = 256'h000102030405060708090a0b0c0d0e0f10111213141516170000000000000000;
  localparam logic [255:0] K128 = 256'h000102030405060708090a0b0c0d0e0f00000000000000000000000000000000;
  typedef struct {logic [127:0] d; logic e; int c;} exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0, req0_ready, req1_ready;
  logic [2:0] req0_mode = '0, req1_mode = '0, core_mode;
  logic [127:0] req0_text = '0, req1_text = '0, core_text, core_result;
  logic [255:0] req0_key = '0, req1_key = '0, core_key;
  logic resp0_valid, resp1_valid, resp0_err, resp1_err;
  logic resp0_ready = 1'b1, resp1_ready = 1'b1;
  logic [127:0] resp0_data, resp1_data;
  int cyc = 0, n_tests = 0, n_fail = 0, last_acc = 0;
  int acc_log[$];
  exp_t q0[$], q1[$];
  bit pv0 = 1'b0, pv1 = 1'b0;
  // stand-in for the cipher cores: known vectors, otherwise a fixed mixing function
  function automatic logic [127:0] model(input logic [2:0] m, input logic [127:0] t, input logic [255:0] k);
    if (m == 3'b000 && t == PT && k == K128) return C128;
    if (m == 3'b001 && t == PT && k == K192) return C192;
    if (m == 3'b100 && t == C128 && k == K128) return PT;
    return t ^ k[255:128] ^ k[127:0] ^ {125'h0, m};
  endfunction
  assign core_result = model(core_mode, core_text, core_key);
  aes_job_arbiter #(.MC_CYCLES(MC)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode), .req0_text(req0_text), .req0_key(req0_key),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode), .req1_text(req1_text), .req1_key(req1_key),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data), .resp0_err(resp0_err),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data), .resp1_err(resp1_err),
    .core_mode(core_mode), .core_text(core_text), .core_key(core_key), .core_result(core_result)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [255:0] a, input logic [255:0] b);
    n_tests++;
    if (a !== b) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, a, b);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic mon(input bit n, input logic v, input logic r, input logic [127:0] d, input logic e, input bit pv);
    exp_t x;
    if (!v) return;
    if ((n ? q1.size() : q0.size()) == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL resp%0d_unexpected: valid got 1 want 0 (no job outstanding)", n);
      return;
    end
    x = n ? q1[0] : q0[0];
    chk($sformatf("resp%0d_data", n), 256'(d), 256'(x.d));
    chk($sformatf("resp%0d_err", n), 256'(e), 256'(x.e));
    if (!pv) chk($sformatf("resp%0d_latency_cycle", n), 256'(cyc), 256'(x.c));
    if (r) begin
      if (n) void'(q1.pop_front());
      else void'(q0.pop_front());
    end
  endtask
  always @(negedge clk)
    if (rst) begin
      pv0 = 1'b0;
      pv1 = 1'b0;
    end else begin
      mon(1'b0, resp0_valid, resp0_ready, resp0_data, resp0_err, pv0);
      mon(1'b1, resp1_valid, resp1_ready, resp1_data, resp1_err, pv1);
      pv0 = resp0_valid && !resp0_ready;
      pv1 = resp1_valid && !resp1_ready;
    end
  task automatic issue(input bit n, input logic [2:0] m, input logic [127:0] t, input logic [255:0] k,
                       input logic [127:0] d, input bit e, input bit push);
    int w;
    exp_t x;
    w = 0;
    if (n) begin
      req1_valid = 1'b1; req1_mode = m; req1_text = t; req1_key = k;
    end else begin
      req0_valid = 1'b1; req0_mode = m; req0_text = t; req0_key = k;
    end
    do begin
      @(negedge clk);
      w++;
    end while (!(n ? req1_ready : req0_ready) && w < 200);
    if (w >= 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL req%0d_accept_timeout: ready got 0 want 1 within 200 cycles", n);
    end else begin
      acc_log.push_back(int'(n));
      last_acc = cyc;
      if (push) begin
        x.d = d;
        x.e = e;
        x.c = cyc + (e ? 1 : MC + 1);
        if (n) q1.push_back(x);
        else q0.push_back(x);
      end
    end
    @(posedge clk);
    #1;
    if (n) req1_valid = 1'b0;
    else req0_valid = 1'b0;
  endtask
  task automatic drain();
    int w;
    w = 0;
    while ((q0.size() != 0 || q1.size() != 0) && w < 500) begin
      @(negedge clk);
      w++;
    end
    chk("drain_outstanding", 256'(q0.size() + q1.size()), 256'd0);
    tick(1);
  endtask
  initial begin
    int a, w;
    int arb_exp[4] = '{0, 1, 0, 1};
    #1;
    chk("rst_req0_ready", 256'(req0_ready), 256'd0);
    chk("rst_req1_ready", 256'(req1_ready), 256'd0);
    chk("rst_resp0_valid", 256'(resp0_valid), 256'd0);
    chk("rst_resp1_valid", 256'(resp1_valid), 256'd0);
    chk("rst_resp_data", 256'({resp0_data, resp1_data}), 256'd0);
    chk("rst_resp_err", 256'({resp0_err, resp1_err}), 256'd0);
    chk("rst_core_mode", 256'(core_mode), 256'd0);
    chk("rst_core_text", 256'(core_text), 256'd0);
    chk("rst_core_key", core_key, 256'd0);
    tick(2);
    rst = 1'b0;
    tick(1);
    // enc128 vector, then back-to-back dec128 to check throughput
    issue(1'b0, 3'b000, PT, K128, C128, 1'b0, 1'b1);
    a = last_acc;
    issue(1'b0, 3'b100, C128, K128, PT, 1'b0, 1'b1);
    chk("throughput_cycles", 256'(last_acc - a), 256'(MC + 2));
    drain();
    // illegal mode: error response, datapath operands untouched
    issue(1'b1, 3'b011, 128'hdeadbeef, KF, 128'h0, 1'b1, 1'b1);
    drain();
    chk("illegal_core_mode_held", 256'(core_mode), 256'(3'b100));
    chk("illegal_core_text_held", 256'(core_text), 256'(C128));
    chk("illegal_core_key_held", core_key, K128);
    // round-robin from a fresh reset
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    acc_log.delete();
    fork
      begin
        issue(1'b0, 3'b010, 128'h1111, KF, model(3'b010, 128'h1111, KF), 1'b0, 1'b1);
        issue(1'b0, 3'b110, 128'h3333, KF, model(3'b110, 128'h3333, KF), 1'b0, 1'b1);
      end
      begin
        issue(1'b1, 3'b001, 128'h2222, K192, model(3'b001, 128'h2222, K192), 1'b0, 1'b1);
        issue(1'b1, 3'b101, 128'h4444, K192, model(3'b101, 128'h4444, K192), 1'b0, 1'b1);
      end
    join
    drain();
    chk("arb_count", 256'(acc_log.size()), 256'd4);
    for (int i = 0; i < 4 && i < acc_log.size(); i++) chk($sformatf("arb_grant%0d", i), 256'(acc_log[i]), 256'(arb_exp[i]));
    // response backpressure holds off the other requester
    resp0_ready = 1'b0;
    issue(1'b0, 3'b001, PT, K192, C192, 1'b0, 1'b1);
    fork
      issue(1'b1, 3'b110, 128'h5555, KF, model(3'b110, 128'h5555, KF), 1'b0, 1'b1);
    join_none
    w = 0;
    while (!resp0_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("bp_resp0_valid_seen", 256'(resp0_valid), 256'd1);
    repeat (10) begin
      @(negedge clk);
      chk("bp_req1_ready_low", 256'(req1_ready), 256'd0);
      chk("bp_resp0_valid_held", 256'(resp0_valid), 256'd1);
    end
    @(posedge clk);
    #1;
    resp0_ready = 1'b1;
    @(negedge clk);
    chk("bp_no_bypass_req1_ready", 256'(req1_ready), 256'd0);
    @(negedge clk);
    chk("bp_req1_ready_next", 256'(req1_ready), 256'd1);
    wait fork;
    drain();
    // reset while the job is settling: no response afterwards
    issue(1'b0, 3'b000, PT, K128, C128, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_core_mode", 256'(core_mode), 256'd0);
    chk("midrst_core_text", 256'(core_text), 256'd0);
    chk("midrst_core_key", core_key, 256'd0);
    chk("midrst_resp0_valid", 256'(resp0_valid), 256'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (MC + 6) begin
      @(negedge clk);
      chk("midrst_no_resp0", 256'(resp0_valid), 256'd0);
    end
    chk("final_queues_empty", 256'(q0.size() + q1.size()), 256'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
